// File: rtl/wptr_full.sv
// Write-side pointer and status logic for the async FIFO.
// Keeps the binary and Gray write pointers and compares them against the
// read pointer that has been synchronized into the write domain.
// Produces the RAM write address, full / almost-full, fill level and a
// sticky overflow flag.
// Every output comes from a register or from wbin_q, so wq2_rptr_i has no
// combinational path to any output.
module wptr_full #(
   parameter int ADDRSIZE  = 3,
   parameter int AF_THRESH = 6
) (
   input  logic                wclk_i,
   input  logic                wrst_i,
   input  logic                winc_i,
   input  logic [ADDRSIZE:0]   wq2_rptr_i,
   input  logic                wclr_ovf_i,
   output logic [ADDRSIZE-1:0] waddr_o,
   output logic [ADDRSIZE:0]   wptr_o,
   output logic                wfull_o,
   output logic                walmost_full_o,
   output logic [ADDRSIZE:0]   wlevel_o,
   output logic                woverflow_o
);

   localparam int A = ADDRSIZE;
   localparam logic [A:0] AF_TH = (A+1)'(AF_THRESH);

   logic [A:0] wbin_q, wbin_d;
   logic [A:0] wgray_q, wgray_d;
   logic       wfull_q, wfull_d;
   logic       walmost_full_q, walmost_full_d;
   logic [A:0] wlevel_q, wlevel_d;
   logic       woverflow_q, woverflow_d;

   logic       wr_accept;
   logic [A:0] rbin;
   logic [A:0] full_gray;

   // Gray-to-binary of the synchronized read pointer.
   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rbin = '0;
      for (int i = 0; i <= A; i++) begin
         rbin[i] = ^(wq2_rptr_i >> i);
      end
   end

   // Next-state logic for the pointers, the status flags and the level.
   // The full pattern is the read pointer with its top two Gray bits inverted.
   // That is the Gray code of a pointer exactly one lap (2**A) ahead.
   always_comb begin
      wr_accept      = winc_i & ~wfull_q;
      wbin_d         = wbin_q + {{A{1'b0}}, wr_accept};
      wgray_d        = (wbin_d >> 1) ^ wbin_d;
      full_gray      = {~wq2_rptr_i[A:A-1], wq2_rptr_i[A-2:0]};
      wfull_d        = (wgray_d == full_gray);
      wlevel_d       = wbin_d - rbin;
      walmost_full_d = (wlevel_d >= AF_TH);
      // An overflow attempt in the same cycle as a clear keeps the flag set.
      woverflow_d    = (winc_i & wfull_q) | (woverflow_q & ~wclr_ovf_i);
   end

   // State registers; a synchronous reset takes priority over every other input.
   always_ff @(posedge wclk_i) begin
      if (wrst_i) begin
         wbin_q         <= '0;
         wgray_q        <= '0;
         wfull_q        <= 1'b0;
         walmost_full_q <= 1'b0;
         wlevel_q       <= '0;
         woverflow_q    <= 1'b0;
      end else begin
         wbin_q         <= wbin_d;
         wgray_q        <= wgray_d;
         wfull_q        <= wfull_d;
         walmost_full_q <= walmost_full_d;
         wlevel_q       <= wlevel_d;
         woverflow_q    <= woverflow_d;
      end
   end

   assign waddr_o        = wbin_q[A-1:0];
   assign wptr_o         = wgray_q;
   assign wfull_o        = wfull_q;
   assign walmost_full_o = walmost_full_q;
   assign wlevel_o       = wlevel_q;
   assign woverflow_o    = woverflow_q;

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full with ADDRSIZE=3 and AF_THRESH=6.
module tb_wptr_full;

   logic       wclk;
   logic       wrst;
   logic       winc;
   logic [3:0] wq2_rptr;
   logic       wclr_ovf;
   logic [2:0] waddr;
   logic [3:0] wptr;
   logic       wfull;
   logic       walmost_full;
   logic [3:0] wlevel;
   logic       woverflow;

   int n_assert = 0;
   int n_fail   = 0;

   logic [3:0] gt [16];
   logic [3:0] prev_ptr;
   int         w;

   wptr_full #(.ADDRSIZE(3), .AF_THRESH(6)) dut (
      .wclk_i         (wclk),
      .wrst_i         (wrst),
      .winc_i         (winc),
      .wq2_rptr_i     (wq2_rptr),
      .wclr_ovf_i     (wclr_ovf),
      .waddr_o        (waddr),
      .wptr_o         (wptr),
      .wfull_o        (wfull),
      .walmost_full_o (walmost_full),
      .wlevel_o       (wlevel),
      .woverflow_o    (woverflow)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   task automatic step();
      @(posedge wclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] e_ptr, input logic [2:0] e_addr,
                          input logic e_full, input logic e_af, input logic [3:0] e_lvl,
                          input logic e_ovf);
      chk({tag, ".wptr"},   {4'h0, wptr},         {4'h0, e_ptr});
      chk({tag, ".waddr"},  {5'h0, waddr},        {5'h0, e_addr});
      chk({tag, ".wfull"},  {7'h0, wfull},        {7'h0, e_full});
      chk({tag, ".walmost_full"}, {7'h0, walmost_full}, {7'h0, e_af});
      chk({tag, ".wlevel"}, {4'h0, wlevel},       {4'h0, e_lvl});
      chk({tag, ".woverflow"}, {7'h0, woverflow}, {7'h0, e_ovf});
   endtask

   initial begin
      gt[0]  = 4'b0000; gt[1]  = 4'b0001; gt[2]  = 4'b0011; gt[3]  = 4'b0010;
      gt[4]  = 4'b0110; gt[5]  = 4'b0111; gt[6]  = 4'b0101; gt[7]  = 4'b0100;
      gt[8]  = 4'b1100; gt[9]  = 4'b1101; gt[10] = 4'b1111; gt[11] = 4'b1110;
      gt[12] = 4'b1010; gt[13] = 4'b1011; gt[14] = 4'b1001; gt[15] = 4'b1000;

      wrst = 1'b1; winc = 1'b0; wq2_rptr = 4'b0000; wclr_ovf = 1'b0;

      // reset state
      step();
      chk_all("reset", 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      wrst = 1'b0;

      // fill 8 entries with the read pointer at zero
      winc = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk_all($sformatf("fill%0d", k), gt[k], 3'(k % 8), (k == 8), (k >= 6), 4'(k), 1'b0);
      end

      // write while full is dropped and sets overflow
      step();
      chk_all("ovf_set", 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1);

      // clear alone
      winc = 1'b0; wclr_ovf = 1'b1;
      step();
      chk("ovf_clr", {7'h0, woverflow}, 8'h00);

      // overflow and clear together: set wins
      winc = 1'b1;
      step();
      chk("ovf_set_wins", {7'h0, woverflow}, 8'h01);
      chk("ovf_ptr_hold", {4'h0, wptr}, 8'h0C);
      winc = 1'b0; wclr_ovf = 1'b0;

      // one read becomes visible: full drops, level 7
      wq2_rptr = 4'b0001;
      step();
      chk_all("read1", 4'b1100, 3'd0, 1'b0, 1'b1, 4'd7, 1'b1);

      // next write refills the FIFO
      winc = 1'b1;
      step();
      chk_all("refill", 4'b1101, 3'd1, 1'b1, 1'b1, 4'd8, 1'b1);
      winc = 1'b0;

      // wrap: 16 writes, read pointer trailing two writes behind
      wrst = 1'b1; wq2_rptr = 4'b0000;
      step();
      wrst = 1'b0;
      prev_ptr = wptr;
      winc = 1'b1;
      w = 0;
      for (int k = 1; k <= 16; k++) begin
         wq2_rptr = (w >= 2) ? gt[w-2] : 4'b0000;
         step();
         w++;
         chk($sformatf("wrap%0d.wptr", k),  {4'h0, wptr},  {4'h0, gt[w % 16]});
         chk($sformatf("wrap%0d.waddr", k), {5'h0, waddr}, {5'h0, 3'(w % 8)});
         chk($sformatf("wrap%0d.wfull", k), {7'h0, wfull}, 8'h00);
         chk($sformatf("wrap%0d.wlevel", k), {4'h0, wlevel}, (w >= 3) ? 8'd3 : 8'(w));
         chk($sformatf("wrap%0d.onebit", k), 8'($countones(wptr ^ prev_ptr)), 8'd1);
         prev_ptr = wptr;
      end
      winc = 1'b0;

      // mid-burst reset with level 4 and overflow set
      wrst = 1'b1; wq2_rptr = 4'b0000;
      step();
      wrst = 1'b0;
      winc = 1'b1;
      for (int k = 1; k <= 9; k++) step();
      chk_all("pre_rst_full", 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1);
      // pending read while full: the write in this cycle is still rejected
      wq2_rptr = 4'b0110;
      step();
      chk_all("pend_read", 4'b1100, 3'd0, 1'b0, 1'b0, 4'd4, 1'b1);
      wrst = 1'b1;
      step();
      chk_all("mid_rst", 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      wrst = 1'b0; wq2_rptr = 4'b0000;
      step();
      chk_all("post_rst_wr", 4'b0001, 3'd1, 1'b0, 1'b0, 4'd1, 1'b0);
      winc = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
